// File: rtl/mor1kx_tlb_reload_arbiter.sv
// Shares one single-beat read master between the IMMU and DMMU TLB-reload ports.
// The bus stays locked to one MMU for its whole walk. Round-robin decides ties, and a timeout ends hung beats.
module mor1kx_tlb_reload_arbiter #(
    parameter int OPTION_OPERAND_WIDTH     = 32,
    parameter int OPTION_RELOAD_TIMEOUT    = 256,
    parameter int OPTION_TIMEOUT_CNT_WIDTH = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            immu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
    output logic                            immu_ack_o,
    output logic                            immu_err_o,
    input  logic                            dmmu_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
    output logic                            dmmu_ack_o,
    output logic                            dmmu_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] reload_data_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i,
    output logic [1:0]                      grant_o,
    output logic                            busy_o
);
    localparam int OW = OPTION_OPERAND_WIDTH;
    localparam int CW = OPTION_TIMEOUT_CNT_WIDTH;
    localparam logic [CW-1:0] TMO_LAST = CW'(OPTION_RELOAD_TIMEOUT - 1);
    localparam bit TMO_EN = (OPTION_RELOAD_TIMEOUT != 0);

    typedef enum logic [1:0] {ARB, BUS, RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;      // one-hot lock: bit0 IMMU, bit1 DMMU
    logic          rr_last_q, rr_last_d;  // 1 when DMMU was served last
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] adr_q, adr_d;
    logic [OW-1:0] data_q, data_d;
    logic          cyc_q, cyc_d;
    logic [1:0]    ack_q, ack_d;
    logic [1:0]    err_q, err_d;

    logic [1:0]    req;
    logic          owner_req;
    logic          tmo;
    logic          tmo_only;
    logic [1:0]    lock;
    logic [1:0]    win;
    logic          rr;

    assign req       = {dmmu_req_i, immu_req_i};
    assign owner_req = |(owner_q & req);
    assign tmo       = TMO_EN && (cnt_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        data_d    = data_q;
        cyc_d     = cyc_q;
        ack_d     = 2'b00;
        err_d     = 2'b00;
        lock      = owner_q;
        rr        = rr_last_q;
        win       = 2'b00;
        tmo_only  = tmo && !wbm_ack_i && !wbm_err_i;

        case (state_q)
            ARB: begin
                // A released owner hands over in this same cycle, so the waiting MMU wins immediately.
                if (lock != 2'b00 && !owner_req) begin
                    rr   = lock[1];
                    lock = 2'b00;
                end
                if (lock != 2'b00)
                    win = lock;
                else if (req[0] && (!req[1] || rr))
                    win = 2'b01;
                else if (req[1])
                    win = 2'b10;
                owner_d   = win;
                rr_last_d = rr;
                if (win != 2'b00) begin
                    adr_d   = win[1] ? dmmu_addr_i : immu_addr_i;
                    cyc_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i || wbm_err_i || tmo) begin
                    cyc_d = 1'b0;
                    cnt_d = '0;
                    if (owner_req) begin
                        ack_d   = owner_q;
                        err_d   = (wbm_err_i || tmo_only) ? owner_q : 2'b00;
                        data_d  = tmo_only ? '0 : wbm_dat_i;
                        state_d = RESP;
                    end else begin
                        rr_last_d = owner_q[1];
                        owner_d   = 2'b00;
                        state_d   = ARB;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ARB;
            owner_q   <= 2'b00;
            rr_last_q <= 1'b1;
            cnt_q     <= '0;
            adr_q     <= '0;
            data_q    <= '0;
            cyc_q     <= 1'b0;
            ack_q     <= 2'b00;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            data_q    <= data_d;
            cyc_q     <= cyc_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign immu_ack_o    = ack_q[0];
    assign immu_err_o    = err_q[0];
    assign dmmu_ack_o    = ack_q[1];
    assign dmmu_err_o    = err_q[1];
    assign reload_data_o = data_q;
    assign wbm_adr_o     = adr_q;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_we_o      = 1'b0;
    assign wbm_sel_o     = 4'hf;
    assign grant_o       = owner_q;
    assign busy_o        = (state_q != ARB) || (owner_q != 2'b00);
endmodule

// File: tb/tb_mor1kx_tlb_reload_arbiter.sv
// Bench for the TLB reload arbiter: a transaction-level reference model is checked every cycle.
// Directed walks pin literal values, and a randomized phase follows.
module tb_mor1kx_tlb_reload_arbiter;
    localparam int OW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          immu_req_i = 1'b0, dmmu_req_i = 1'b0;
    logic [OW-1:0] immu_addr_i = '0, dmmu_addr_i = '0, wbm_dat_i = '0;
    logic          wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
    logic          immu_ack_o, immu_err_o, dmmu_ack_o, dmmu_err_o;
    logic [OW-1:0] reload_data_o, wbm_adr_o;
    logic          wbm_cyc_o, wbm_stb_o, wbm_we_o, busy_o;
    logic [3:0]    wbm_sel_o;
    logic [1:0]    grant_o;

    mor1kx_tlb_reload_arbiter #(
        .OPTION_OPERAND_WIDTH(OW),
        .OPTION_RELOAD_TIMEOUT(TO),
        .OPTION_TIMEOUT_CNT_WIDTH(5)
    ) dut (
        .clk(clk), .rst(rst),
        .immu_req_i(immu_req_i), .immu_addr_i(immu_addr_i),
        .immu_ack_o(immu_ack_o), .immu_err_o(immu_err_o),
        .dmmu_req_i(dmmu_req_i), .dmmu_addr_i(dmmu_addr_i),
        .dmmu_ack_o(dmmu_ack_o), .dmmu_err_o(dmmu_err_o),
        .reload_data_o(reload_data_o),
        .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference model: owner index (-1 = none), who was served last, and whether a beat or response is in flight.
    int          m_owner = -1;
    int          m_last  = 1;
    bit          m_bus   = 1'b0;
    bit          m_resp  = 1'b0;
    int          m_age   = 0;
    logic        e_cyc = 1'b0, e_iack = 1'b0, e_ierr = 1'b0, e_dack = 1'b0, e_derr = 1'b0;
    logic [31:0] e_adr = '0, e_data = '0;

    task automatic model_step();
        bit          r [2];
        logic [31:0] a [2];
        bit          tmo, ok_ack, ok_err;
        r[0] = immu_req_i;  r[1] = dmmu_req_i;
        a[0] = immu_addr_i; a[1] = dmmu_addr_i;
        e_iack = 1'b0; e_ierr = 1'b0; e_dack = 1'b0; e_derr = 1'b0;
        if (!rst) begin
            m_owner = -1; m_last = 1; m_bus = 1'b0; m_resp = 1'b0; m_age = 0;
            e_cyc = 1'b0; e_adr = '0; e_data = '0;
        end else if (m_bus) begin
            tmo    = (TO != 0) && (m_age == TO - 1);
            ok_ack = wbm_ack_i;
            ok_err = wbm_err_i;
            if (ok_ack || ok_err || tmo) begin
                m_bus = 1'b0;
                e_cyc = 1'b0;
                if (r[m_owner]) begin
                    if (m_owner == 0) begin
                        e_iack = 1'b1; e_ierr = ok_err || !ok_ack;
                    end else begin
                        e_dack = 1'b1; e_derr = ok_err || !ok_ack;
                    end
                    e_data = (ok_ack || ok_err) ? wbm_dat_i : 32'h0;
                    m_resp = 1'b1;
                end else begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else begin
                m_age++;
            end
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else begin
            if (m_owner >= 0 && !r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end
            if (m_owner < 0) begin
                if (r[0] && r[1]) m_owner = 1 - m_last;
                else if (r[0])    m_owner = 0;
                else if (r[1])    m_owner = 1;
            end
            if (m_owner >= 0) begin
                e_adr = a[m_owner];
                e_cyc = 1'b1;
                m_bus = 1'b1;
                m_age = 0;
            end
        end
    endtask

    function automatic logic [1:0] m_grant();
        return {m_owner == 1, m_owner == 0};
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cyc",   wbm_cyc_o,     e_cyc);
            check("stb",   wbm_stb_o,     e_cyc);
            check("adr",   wbm_adr_o,     e_adr);
            check("iack",  immu_ack_o,    e_iack);
            check("ierr",  immu_err_o,    e_ierr);
            check("dack",  dmmu_ack_o,    e_dack);
            check("derr",  dmmu_err_o,    e_derr);
            check("data",  reload_data_o, e_data);
            check("grant", grant_o,       m_grant());
            check("busy",  busy_o,        (m_bus || m_resp || m_owner >= 0));
            check("we",    wbm_we_o,      1'b0);
            check("sel",   wbm_sel_o,     4'hf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n;
    int stall;

    initial begin
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b1;
        check("rst_cyc",   wbm_cyc_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_data",  reload_data_o, 0);

        // DMMU walk with IMMU waiting
        immu_addr_i = 32'h0000_1000;
        dmmu_req_i = 1'b1; dmmu_addr_i = 32'h0040_0008; tick();
        check("t1_cyc", wbm_cyc_o, 1);
        check("t1_adr", wbm_adr_o, 32'h0040_0008);
        check("t1_grant", grant_o, 2'b10);
        immu_req_i = 1'b1; tick();
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0123_6000; tick();
        check("t1_dack", dmmu_ack_o, 1);
        check("t1_derr", dmmu_err_o, 0);
        check("t1_data", reload_data_o, 32'h0123_6000);
        check("t1_cyc_drop", wbm_cyc_o, 0);
        wbm_ack_i = 1'b0; dmmu_addr_i = 32'h0123_6804; tick();
        check("t1_dack_pulse", dmmu_ack_o, 0);
        tick();
        check("t1_beat2_cyc", wbm_cyc_o, 1);
        check("t1_beat2_adr", wbm_adr_o, 32'h0123_6804);
        check("t1_beat2_grant", grant_o, 2'b10);
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0; tick();
        check("t1_beat2_dack", dmmu_ack_o, 1);
        wbm_ack_i = 1'b0; dmmu_req_i = 1'b0; tick();
        check("t1_lock_kept", grant_o, 2'b10);
        tick();
        check("t1_immu_grant", grant_o, 2'b01);
        check("t1_immu_adr", wbm_adr_o, 32'h0000_1000);
        wbm_ack_i = 1'b1; tick();
        wbm_ack_i = 1'b0; immu_req_i = 1'b0; tick();
        tick();
        check("t1_idle_busy", busy_o, 0);

        // Fairness from reset
        rst = 1'b0; tick(); rst = 1'b1;
        immu_req_i = 1'b1; dmmu_req_i = 1'b1; tick();
        check("t2_first_immu", grant_o, 2'b01);
        check("t2_model_first", m_grant(), 2'b01);
        wbm_ack_i = 1'b1; tick();
        check("t2_iack", immu_ack_o, 1);
        wbm_ack_i = 1'b0; immu_req_i = 1'b0; tick();
        tick();
        check("t2_handover", grant_o, 2'b10);
        check("t2_model_handover", m_grant(), 2'b10);
        check("t2_handover_cyc", wbm_cyc_o, 1);
        wbm_ack_i = 1'b1; tick();
        check("t2_dack", dmmu_ack_o, 1);
        wbm_ack_i = 1'b0; dmmu_req_i = 1'b0; tick();
        tick();
        check("t2_free", grant_o, 2'b00);
        immu_req_i = 1'b1; dmmu_req_i = 1'b1; tick();
        check("t2_rerequest_immu", grant_o, 2'b01);
        wbm_ack_i = 1'b1; tick();
        wbm_ack_i = 1'b0; immu_req_i = 1'b0; dmmu_req_i = 1'b0; tick();
        tick();

        // Bus error
        immu_req_i = 1'b1; immu_addr_i = 32'h0000_2000; tick();
        check("t3_cyc", wbm_cyc_o, 1);
        wbm_err_i = 1'b1; tick();
        check("t3_iack", immu_ack_o, 1);
        check("t3_ierr", immu_err_o, 1);
        check("t3_cyc_drop", wbm_cyc_o, 0);
        wbm_err_i = 1'b0; immu_req_i = 1'b0; tick();
        check("t3_iack_pulse", immu_ack_o, 0);
        check("t3_cyc_low", wbm_cyc_o, 0);
        tick();

        // Timeout
        wbm_dat_i = 32'hDEAD_BEEF;
        dmmu_req_i = 1'b1; tick();
        n = 0;
        while (wbm_cyc_o === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("t4_cyc_cycles", n, 16);
        check("t4_dack", dmmu_ack_o, 1);
        check("t4_derr", dmmu_err_o, 1);
        check("t4_data", reload_data_o, 32'h0);
        dmmu_req_i = 1'b0; tick();
        tick();

        // Abort mid-beat
        dmmu_req_i = 1'b1; tick();
        check("t5_grant", grant_o, 2'b10);
        immu_req_i = 1'b1; tick();
        dmmu_req_i = 1'b0; tick();
        check("t5_cyc_held1", wbm_cyc_o, 1);
        tick();
        check("t5_cyc_held2", wbm_cyc_o, 1);
        wbm_ack_i = 1'b1; tick();
        check("t5_cyc_drop", wbm_cyc_o, 0);
        check("t5_no_dack", dmmu_ack_o, 0);
        wbm_ack_i = 1'b0; tick();
        check("t5_immu_grant", grant_o, 2'b01);
        check("t5_immu_cyc", wbm_cyc_o, 1);

        // Reset during a beat
        rst = 1'b0; tick();
        check("t6_cyc", wbm_cyc_o, 0);
        check("t6_grant", grant_o, 0);
        check("t6_iack", immu_ack_o, 0);
        rst = 1'b1; wbm_ack_i = 1'b1; tick();
        check("t6_no_pulse", immu_ack_o, 0);
        wbm_ack_i = 1'b0; immu_req_i = 1'b0; tick();
        wbm_ack_i = 1'b1; tick();
        wbm_ack_i = 1'b0; tick();

        // Randomized traffic
        stall = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) immu_req_i = ~immu_req_i;
            if ($urandom_range(0, 15) == 0) dmmu_req_i = ~dmmu_req_i;
            if ($urandom_range(0, 3) == 0) immu_addr_i = $urandom;
            if ($urandom_range(0, 3) == 0) dmmu_addr_i = $urandom;
            if (stall > 0) stall--;
            else if ($urandom_range(0, 99) == 0) stall = $urandom_range(10, 30);
            wbm_ack_i = (stall == 0) && ($urandom_range(0, 3) == 0);
            wbm_err_i = (stall == 0) && ($urandom_range(0, 11) == 0);
            wbm_dat_i = $urandom;
            rst = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
